// File: rtl/rx_cmd_pkg.sv
// Shared constants for the command-line parser: ASCII codes, FSM states
// and commit targets.
package rx_cmd_pkg;

    localparam logic [7:0] CHR_A     = 8'h61;  // 'a'
    localparam logic [7:0] CHR_B     = 8'h62;  // 'b'
    localparam logic [7:0] CHR_O     = 8'h6F;  // 'o'
    localparam logic [7:0] CHR_D     = 8'h64;  // 'd'
    localparam logic [7:0] CHR_MINUS = 8'h2D;  // '-'
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_9     = 8'h39;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SIGN    = 3'd1,
        DIGIT   = 3'd2,
        WAIT_CR = 3'd3,
        DISCARD = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TGT_A  = 2'd0,
        TGT_B  = 2'd1,
        TGT_OP = 2'd2
    } tgt_t;

endpackage

// File: rtl/rx_cmd_parser_dec_accum.sv
// Decimal accumulator: collects up to three ASCII digits into a 10-bit
// magnitude and flags a fourth digit as overflow.
module dec_accum (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active-low
    input  logic       clear,
    input  logic       load,
    input  logic       shift,
    input  logic       digit_vld,
    input  logic [3:0] digit,
    output logic [9:0] acc,
    output logic [1:0] count,
    output logic       ovf
);

    // A digit arriving with three already held cannot be represented.
    assign ovf = digit_vld && (count == 2'd3);

    // Clear wins over load, load over shift-in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= {6'd0, digit};
            count <= 2'd1;
        end else if (shift) begin
            acc   <= (acc * 10'd10) + {6'd0, digit};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/rx_cmd_parser.sv
// ASCII command-line parser between uart_rx and the ALU/transmit path.
// Lines: a|b|o [-] 1..3 digits CR, or d CR; LF ignored everywhere.
// Build option: RX_UPPERCASE_EN accepts 'A','B','O','D' as commands.
module rx_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OPW  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done_tick,
    input  logic [7:0]             dout,
    input  logic                   rd,
    output logic signed [DBIT-1:0] a_out,
    output logic signed [DBIT-1:0] b_out,
    output logic [OPW-1:0]         op_out,
    output logic                   show,
    output logic                   err_tick
);

    state_t     state, state_n;
    tgt_t       tgt, tgt_n;
    logic       neg, neg_n;
    logic [7:0] cmd;
    logic       is_cr, is_lf, is_minus, is_digit;
    logic       acc_clear, acc_load, acc_shift, digit_vld, ovf;
    logic [9:0] acc;
    logic [1:0] count;
    logic       commit, err_set, show_set;

    // Magnitude fits the target register for the given sign.
    function automatic logic range_ok(input logic [9:0] mag, input logic is_neg, input tgt_t t);
        int v;
        v = int'(mag);
        if (t == TGT_OP)
            return v <= (1 << OPW) - 1;
        else if (is_neg)
            return v <= (1 << (DBIT - 1));
        else
            return v <= (1 << (DBIT - 1)) - 1;
    endfunction

    // Two's complement value of a sign/magnitude pair; "-0" gives 0.
    function automatic logic signed [DBIT-1:0] to_signed(input logic [9:0] mag, input logic is_neg);
        logic signed [DBIT-1:0] m;
        m = DBIT'(mag);
        return is_neg ? -m : m;
    endfunction

`ifdef RX_UPPERCASE_EN
    assign cmd = (dout >= 8'h41 && dout <= 8'h5A) ? (dout | 8'h20) : dout;
`else
    assign cmd = dout;
`endif

    assign is_cr     = (dout == CHR_CR);
    assign is_lf     = (dout == CHR_LF);
    assign is_minus  = (dout == CHR_MINUS);
    assign is_digit  = (dout >= CHR_0) && (dout <= CHR_9);
    assign digit_vld = rx_done_tick && is_digit && (state == DIGIT);

    dec_accum u_accum (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear),
        .load      (acc_load),
        .shift     (acc_shift),
        .digit_vld (digit_vld),
        .digit     (dout[3:0]),
        .acc       (acc),
        .count     (count),
        .ovf       (ovf)
    );

    // FSM state, target and sign registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tgt   <= TGT_A;
            neg   <= 1'b0;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            neg   <= neg_n;
        end
    end

    // Next-state decode of one received byte, range check on CR.
    always_comb begin
        state_n   = state;
        tgt_n     = tgt;
        neg_n     = neg;
        acc_clear = 1'b0;
        acc_load  = 1'b0;
        acc_shift = 1'b0;
        commit    = 1'b0;
        err_set   = 1'b0;
        show_set  = 1'b0;
        if (rx_done_tick && !is_lf) begin
            case (state)
                IDLE: begin
                    if (cmd == CHR_A || cmd == CHR_B || cmd == CHR_O) begin
                        state_n   = SIGN;
                        neg_n     = 1'b0;
                        acc_clear = 1'b1;
                        tgt_n     = (cmd == CHR_A) ? TGT_A : (cmd == CHR_B) ? TGT_B : TGT_OP;
                    end else if (cmd == CHR_D) begin
                        state_n = WAIT_CR;
                    end else if (!is_cr) begin
                        state_n = DISCARD;
                    end
                end
                SIGN: begin
                    if (is_minus && tgt != TGT_OP) begin
                        state_n = DIGIT;
                        neg_n   = 1'b1;
                    end else if (is_digit) begin
                        state_n  = DIGIT;
                        acc_load = 1'b1;
                    end else begin
                        state_n = DISCARD;
                    end
                end
                DIGIT: begin
                    if (is_digit) begin
                        if (ovf)
                            state_n = DISCARD;
                        else
                            acc_shift = 1'b1;
                    end else if (is_cr && count != 2'd0) begin
                        state_n = IDLE;
                        if (range_ok(acc, neg, tgt))
                            commit = 1'b1;
                        else
                            err_set = 1'b1;
                    end else begin
                        state_n = DISCARD;
                    end
                end
                WAIT_CR: begin
                    if (is_cr) begin
                        show_set = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        state_n = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_cr) begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Committed operand and opcode registers; only the line's target moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_out  <= '0;
            b_out  <= '0;
            op_out <= '0;
        end else if (commit) begin
            case (tgt)
                TGT_A:   a_out  <= to_signed(acc, neg);
                TGT_B:   b_out  <= to_signed(acc, neg);
                TGT_OP:  op_out <= OPW'(acc);
                default: ;
            endcase
        end
    end

    // Display request held until acknowledged; a new request beats rd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            show <= 1'b0;
        else if (show_set)
            show <= 1'b1;
        else if (rd)
            show <= 1'b0;
    end

    // Single-cycle reject pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_tick <= 1'b0;
        else
            err_tick <= err_set;
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Bench for rx_cmd_parser: directed command lines followed by random byte
// streams, compared every cycle against a line-level reference model.
module tb_rx_cmd_parser;

    localparam int DBIT = 8;
    localparam int OPW  = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   rx_done_tick;
    logic [7:0]             dout;
    logic                   rd;
    logic signed [DBIT-1:0] a_out;
    logic signed [DBIT-1:0] b_out;
    logic [OPW-1:0]         op_out;
    logic                   show;
    logic                   err_tick;

    rx_cmd_parser #(.DBIT(DBIT), .OPW(OPW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .rd           (rd),
        .a_out        (a_out),
        .b_out        (b_out),
        .op_out       (op_out),
        .show         (show),
        .err_tick     (err_tick)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;

    // Reference model: the current line as text plus a "reject until CR" flag.
    byte lbuf[$];
    bit  disc;
    int  ma, mb, mop;
    bit  mshow, merr;

    function automatic byte lc(byte c);
`ifdef RX_UPPERCASE_EN
        if (c == "A" || c == "B" || c == "O" || c == "D") return c + 8'sd32;
`endif
        return c;
    endfunction

    function automatic bit isdig(byte c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic int sign_len();
        return (lbuf.size() > 1 && lbuf[1] == "-") ? 1 : 0;
    endfunction

    // Is the text so far still the start of some legal line?
    function automatic bit prefix_ok();
        byte c;
        int  first;
        if (lbuf.size() == 0) return 1'b1;
        c = lc(lbuf[0]);
        if (c == "d") return lbuf.size() == 1;
        if (!(c == "a" || c == "b" || c == "o")) return 1'b0;
        if (sign_len() == 1 && c == "o") return 1'b0;
        first = 1 + sign_len();
        if (lbuf.size() - first > 3) return 1'b0;
        for (int k = first; k < lbuf.size(); k++)
            if (!isdig(lbuf[k])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit complete();
        if (!prefix_ok() || lbuf.size() == 0) return 1'b0;
        if (lc(lbuf[0]) == "d") return 1'b1;
        return (lbuf.size() - 1 - sign_len()) >= 1;
    endfunction

    // Apply one clock edge to the model.
    task automatic model_edge(bit hb, byte b, bit rdv);
        bit sset;
        byte c;
        int  val, lo, hi;
        merr = 1'b0;
        sset = 1'b0;
        if (hb && b != 8'd10) begin
            if (disc) begin
                if (b == 8'd13) begin
                    merr = 1'b1;
                    disc = 1'b0;
                end
            end else if (b == 8'd13) begin
                if (lbuf.size() != 0) begin
                    if (complete()) begin
                        c = lc(lbuf[0]);
                        if (c == "d") begin
                            sset = 1'b1;
                        end else begin
                            val = 0;
                            for (int k = 1 + sign_len(); k < lbuf.size(); k++)
                                val = val * 10 + int'(lbuf[k] - "0");
                            if (sign_len() == 1) val = -val;
                            lo = (c == "o") ? 0 : -(1 << (DBIT - 1));
                            hi = (c == "o") ? (1 << OPW) - 1 : (1 << (DBIT - 1)) - 1;
                            if (val < lo || val > hi) merr = 1'b1;
                            else if (c == "a") ma = val;
                            else if (c == "b") mb = val;
                            else mop = val;
                        end
                    end else begin
                        disc = 1'b1;
                    end
                    lbuf.delete();
                end
            end else begin
                lbuf.push_back(b);
                if (!prefix_ok()) begin
                    disc = 1'b1;
                    lbuf.delete();
                end
            end
        end
        if (sset) mshow = 1'b1;
        else if (rdv) mshow = 1'b0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("err_tick", {31'd0, err_tick}, {31'd0, merr});
        check("a_out",    {24'd0, a_out},    {24'd0, 8'(ma)});
        check("b_out",    {24'd0, b_out},    {24'd0, 8'(mb)});
        check("op_out",   {26'd0, op_out},   {26'd0, 6'(mop)});
        check("show",     {31'd0, show},     {31'd0, mshow});
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic cycle(bit hb, byte b, bit rdv);
        @(negedge clk);
        rx_done_tick = hb;
        dout         = hb ? 8'(b) : 8'($urandom);
        rd           = rdv;
        @(posedge clk);
        #1;
        model_edge(hb, b, rdv);
        if (err_tick) err_seen++;
        check_all();
    endtask

    task automatic send_text(string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, byte'(s[i]), 1'b0);
    endtask

    task automatic send_line(string s);
        send_text(s);
        cycle(1'b1, 8'd13, 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd           = 1'b0;
        reset        = 1'b0;
        #2;
        lbuf.delete();
        disc  = 1'b0;
        ma    = 0;
        mb    = 0;
        mop   = 0;
        mshow = 1'b0;
        merr  = 1'b0;
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        string alpha;
        int    r;
        bit    hb;
        byte   b;
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        dout         = 8'd0;
        rd           = 1'b0;
        do_reset();

        // Boundary values commit.
        err_seen = 0;
        send_line("a-128");
        send_line("b127");
        send_line("o37");
        check("a_min", {24'd0, a_out}, 32'h80);
        check("b_max", {24'd0, b_out}, 32'h7F);
        check("op_37", {26'd0, op_out}, 32'd37);
        check("no_err_legal", err_seen, 0);

        // Out-of-range values rejected.
        err_seen = 0;
        send_line("a128");
        send_line("b-129");
        check("range_errs", err_seen, 2);
        check("a_kept", {24'd0, a_out}, 32'h80);
        check("b_kept", {24'd0, b_out}, 32'h7F);

        // Malformed lines rejected, then a good one.
        err_seen = 0;
        send_line("a12x5");
        send_line("a1234");
        check("syntax_errs", err_seen, 2);
        send_line("a5");
        check("a_5", {24'd0, a_out}, 32'd5);
        send_line("o-1");
        send_line("o64");
        send_line("a-0");
        check("a_neg0", {24'd0, a_out}, 32'd0);

        // Display request handshake.
        send_text("d");
        cycle(1'b1, 8'd13, 1'b0);
        check("show_set", {31'd0, show}, 32'd1);
        for (int i = 0; i < 100; i++) cycle(1'b0, 8'd0, 1'b0);
        check("show_held", {31'd0, show}, 32'd1);
        cycle(1'b0, 8'd0, 1'b1);
        check("show_clr", {31'd0, show}, 32'd0);
        send_text("d");
        cycle(1'b1, 8'd13, 1'b1);
        check("show_set_wins", {31'd0, show}, 32'd1);
        cycle(1'b0, 8'd0, 1'b1);

        // Reset in the middle of a line.
        send_line("a9");
        send_text("a4");
        do_reset();
        err_seen = 0;
        send_line("2");
        check("rst_a", {24'd0, a_out}, 32'd0);
        check("rst_err", err_seen, 1);

        // Uppercase command.
        err_seen = 0;
        send_line("A7");
`ifdef RX_UPPERCASE_EN
        check("upper_a", {24'd0, a_out}, 32'd7);
`else
        check("upper_err", err_seen, 1);
        check("upper_a", {24'd0, a_out}, 32'd0);
`endif

        // LF inside a line is transparent.
        send_text("b-");
        cycle(1'b1, 8'd10, 1'b0);
        send_line("42");
        check("lf_b", {24'd0, b_out}, 32'(8'hD6));

        // Random byte streams, biased towards plausible lines.
        alpha = "abodABOD-0123456789x";
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 99);
            hb = ($urandom_range(0, 3) != 0);
            if (r < 14) b = 8'd13;
            else if (r < 17) b = 8'd10;
            else if (r < 55) b = byte'(alpha[$urandom_range(9, 18)]);
            else b = byte'(alpha[$urandom_range(0, alpha.len() - 1)]);
            cycle(hb, b, ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
